// File: rtl/acond_pkg.sv
// Shared definitions for the acquisition/conditioning path: state encoding, default word sizes.
package acond_pkg;

  localparam int ACOND_DATA_W     = 12;
  localparam int ACOND_FRAME_BITS = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_QUIET = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    SHIFT = S_SHIFT,
    QUIET = S_QUIET
  } state_t;

  // Counter width that never collapses to zero bits for tiny terminal counts.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK divider: toggles SCLK every CLK_DIV cycles while enabled, idles high, strobes each 0->1 edge.
// sclk_rise is combinational and marks the clock edge that drives SCLK high; no backpressure.
module adc_sclk_gen
  import acond_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic sclk,
  output logic sclk_rise
);

  localparam int DW = cnt_w(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic          div_tc;

  assign div_tc    = (div_cnt == DW'(CLK_DIV - 1));
  assign sclk_rise = en && div_tc && !sclk;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      div_cnt <= '0;
      sclk    <= 1'b1;
    end else if (en) begin
      if (div_tc) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_dual_serial_capture.sv
// Dual serial ADC capture: drives shared CS_N/SCLK, deserialises I and V frames, raises EOC.
// EOC rises 2*CLK_DIV*FRAME_BITS+QUIET_CYC cycles after the start edge; START_ADC outside IDLE is dropped.
module adc_dual_serial_capture
  import acond_pkg::*;
#(
  parameter int DATA_W     = ACOND_DATA_W,
  parameter int FRAME_BITS = ACOND_FRAME_BITS,
  parameter int CLK_DIV    = 2,
  parameter int QUIET_CYC  = 4,
  parameter int AUTO_START = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START_ADC,
  input  logic              SDATA_I,
  input  logic              SDATA_V,
  output logic              CS_N,
  output logic              SCLK,
  output logic [DATA_W-1:0] ADC_I,
  output logic [DATA_W-1:0] ADC_V,
  output logic              EOC,
  output logic              BUSY,
  output logic              FRAME_ERR
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int QW = cnt_w(QUIET_CYC + 1);

  state_t                state, state_nxt;
  logic [BW-1:0]         bit_cnt;
  logic [QW-1:0]         quiet_cnt;
  logic [FRAME_BITS-1:0] sh_i, sh_v;
  logic                  auto_done;
  logic                  start_evt;
  logic                  accept, frame_end, quiet_end;
  logic                  sclk_rise;
  logic                  upper_err;

  adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk      (CLK),
    .rst_n    (RESET),
    .clr      (state != SHIFT),
    .en       (state == SHIFT),
    .sclk     (SCLK),
    .sclk_rise(sclk_rise)
  );

  // The first edge out of reset counts as a start when auto-start is enabled.
  assign start_evt = START_ADC | ((AUTO_START != 0) & ~auto_done);

  generate
    if (FRAME_BITS > DATA_W) begin : g_upper
      assign upper_err = (|sh_i[FRAME_BITS-1:DATA_W]) | (|sh_v[FRAME_BITS-1:DATA_W]);
    end else begin : g_no_upper
      assign upper_err = 1'b0;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    frame_end = 1'b0;
    quiet_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_evt) begin
          state_nxt = SHIFT;
          accept    = 1'b1;
        end
      end
      SHIFT: begin
        if (sclk_rise && (bit_cnt == BW'(FRAME_BITS - 1))) begin
          state_nxt = QUIET;
          frame_end = 1'b1;
        end
      end
      QUIET: begin
        if (quiet_cnt == QW'(QUIET_CYC - 1)) begin
          state_nxt = IDLE;
          quiet_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      CS_N      <= 1'b1;
      EOC       <= 1'b0;
      BUSY      <= 1'b0;
      ADC_I     <= '0;
      ADC_V     <= '0;
      FRAME_ERR <= 1'b0;
      bit_cnt   <= '0;
      quiet_cnt <= '0;
      sh_i      <= '0;
      sh_v      <= '0;
      auto_done <= 1'b0;
    end else begin
      auto_done <= 1'b1;
      if (accept) begin
        CS_N    <= 1'b0;
        EOC     <= 1'b0;
        BUSY    <= 1'b1;
        bit_cnt <= '0;
      end
      if (sclk_rise) begin
        sh_i    <= {sh_i[FRAME_BITS-2:0], SDATA_I};
        sh_v    <= {sh_v[FRAME_BITS-2:0], SDATA_V};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (frame_end) begin
        CS_N      <= 1'b1;
        quiet_cnt <= '0;
      end
      if (state == QUIET) begin
        quiet_cnt <= quiet_end ? '0 : quiet_cnt + QW'(1);
      end
      // Both words and the error flag commit together so readers never see a mixed frame.
      if (quiet_end) begin
        ADC_I     <= sh_i[DATA_W-1:0];
        ADC_V     <= sh_v[DATA_W-1:0];
        FRAME_ERR <= upper_err;
        EOC       <= 1'b1;
        BUSY      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_dual_serial_capture.sv
// Bench for adc_dual_serial_capture: two configurations, ADC frame model, scoreboard checked on EOC.
module tb_adc_dual_serial_capture;

  typedef struct {
    logic [11:0] i;
    logic [11:0] v;
    logic        e;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [2];
  logic        start_adc [2];
  logic        sdata_i   [2];
  logic        sdata_v   [2];
  logic        cs_n      [2];
  logic        sclk      [2];
  logic [11:0] adc_i     [2];
  logic [11:0] adc_v     [2];
  logic        eoc       [2];
  logic        busy      [2];
  logic        ferr      [2];

  adc_dual_serial_capture #(
    .DATA_W(12), .FRAME_BITS(16), .CLK_DIV(2), .QUIET_CYC(4), .AUTO_START(1)
  ) dut0 (
    .CLK(clk), .RESET(reset[0]), .START_ADC(start_adc[0]),
    .SDATA_I(sdata_i[0]), .SDATA_V(sdata_v[0]),
    .CS_N(cs_n[0]), .SCLK(sclk[0]), .ADC_I(adc_i[0]), .ADC_V(adc_v[0]),
    .EOC(eoc[0]), .BUSY(busy[0]), .FRAME_ERR(ferr[0])
  );

  adc_dual_serial_capture #(
    .DATA_W(12), .FRAME_BITS(16), .CLK_DIV(1), .QUIET_CYC(1), .AUTO_START(0)
  ) dut1 (
    .CLK(clk), .RESET(reset[1]), .START_ADC(start_adc[1]),
    .SDATA_I(sdata_i[1]), .SDATA_V(sdata_v[1]),
    .CS_N(cs_n[1]), .SCLK(sclk[1]), .ADC_I(adc_i[1]), .ADC_V(adc_v[1]),
    .EOC(eoc[1]), .BUSY(busy[1]), .FRAME_ERR(ferr[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int cur    = 0;

  logic [15:0] dir_i [$];
  logic [15:0] dir_v [$];
  exp_t        sb    [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] rnd_frame();
    logic [15:0] f;
    f = 16'($urandom);
    if ($urandom_range(0, 3) != 0) f[15:12] = 4'h0;
    return f;
  endfunction

  function automatic int latency(input int idx);
    int div, quiet;
    div   = (idx == 0) ? 2 : 1;
    quiet = (idx == 0) ? 4 : 1;
    return 2 * div * 16 + quiet;
  endfunction

  // ADC model and monitor for the selected instance, evaluated away from the active edge.
  logic [15:0] fi, fv;
  logic [11:0] held_i, held_v;
  logic        p_cs, p_sclk, p_eoc;
  int          fall_cnt, rises;

  always @(negedge clk) begin
    exp_t e;
    if (!reset[cur]) begin
      sb.delete();
      held_i   = '0;
      held_v   = '0;
      p_cs     = 1'b1;
      p_sclk   = 1'b1;
      p_eoc    = 1'b0;
      fall_cnt = 0;
      rises    = 0;
    end else begin
      if (p_cs && !cs_n[cur]) begin
        if (dir_i.size() > 0) begin
          fi = dir_i.pop_front();
          fv = dir_v.pop_front();
        end else begin
          fi = rnd_frame();
          fv = rnd_frame();
        end
        sb.push_back('{i: 12'(fi % 4096), v: 12'(fv % 4096),
                       e: ((fi / 4096) != 0) || ((fv / 4096) != 0), t0: cyc});
        fall_cnt = 0;
        rises    = 0;
        sdata_i[cur] = fi[15];
        sdata_v[cur] = fv[15];
      end
      if (!cs_n[cur] && p_sclk && !sclk[cur]) begin
        fall_cnt++;
        if (fall_cnt <= 16) begin
          sdata_i[cur] = fi[16 - fall_cnt];
          sdata_v[cur] = fv[16 - fall_cnt];
        end
      end
      if (!p_cs && !p_sclk && sclk[cur]) rises++;
      if (!p_eoc && eoc[cur]) begin
        if (sb.size() == 0) begin
          check("unexpected_eoc", 1, 0);
        end else begin
          e = sb.pop_front();
          check("adc_i", adc_i[cur], e.i);
          check("adc_v", adc_v[cur], e.v);
          check("frame_err", ferr[cur], e.e);
          check("eoc_latency", cyc - e.t0, latency(cur));
          check("sclk_rises", rises, 16);
          check("busy_at_eoc", busy[cur], 0);
          held_i = e.i;
          held_v = e.v;
        end
      end else begin
        check("adc_i_hold", adc_i[cur], held_i);
        check("adc_v_hold", adc_v[cur], held_v);
      end
      p_cs   = cs_n[cur];
      p_sclk = sclk[cur];
      p_eoc  = eoc[cur];
    end
  end

  // Called #1 after a posedge; the following edge accepts the request.
  task automatic pulse_start();
    start_adc[cur] = 1'b1;
    @(posedge clk); #1;
    start_adc[cur] = 1'b0;
    check("start_eoc_low", eoc[cur], 0);
    check("start_busy", busy[cur], 1);
    check("start_cs_low", cs_n[cur], 0);
    check("start_sclk_high", sclk[cur], 1);
  endtask

  task automatic wait_eoc();
    int n;
    n = 0;
    while (!eoc[cur] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("eoc_seen", eoc[cur], 1);
  endtask

  task automatic random_runs(input int count);
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 8)) @(posedge clk);
      #1;
      pulse_start();
      wait_eoc();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b0; start_adc[k] = 1'b0; sdata_i[k] = 1'b0; sdata_v[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_cs_n", cs_n[k], 1);
      check("rst_sclk", sclk[k], 1);
      check("rst_eoc", eoc[k], 0);
      check("rst_busy", busy[k], 0);
      check("rst_adc_i", adc_i[k], 0);
      check("rst_adc_v", adc_v[k], 0);
      check("rst_ferr", ferr[k], 0);
    end

    // Auto-start on reset release.
    dir_i.push_back(16'h0ABC); dir_v.push_back(16'h0123);
    reset[0] = 1'b1;
    @(posedge clk); #1;
    check("auto_cs_low", cs_n[0], 0);
    check("auto_busy", busy[0], 1);
    wait_eoc();
    check("auto_adc_i", adc_i[0], 12'hABC);
    check("auto_adc_v", adc_v[0], 12'h123);

    // Full-scale / zero words, requested straight after EOC.
    dir_i.push_back(16'h0FFF); dir_v.push_back(16'h0000);
    pulse_start();
    wait_eoc();

    // Requests mid-conversion must be ignored.
    @(posedge clk); #1;
    pulse_start();
    repeat (4) @(posedge clk);
    #1 start_adc[0] = 1'b1;
    @(posedge clk); #1 start_adc[0] = 1'b0;
    repeat (34) @(posedge clk);
    #1 start_adc[0] = 1'b1;
    @(posedge clk); #1 start_adc[0] = 1'b0;
    wait_eoc();
    repeat (90) @(posedge clk);
    #1;
    check("ignored_no_refire_eoc", eoc[0], 1);
    check("ignored_no_refire_busy", busy[0], 0);
    check("ignored_single_frame", sb.size(), 0);

    // Leading-bit violation on V only, then a clean frame.
    dir_i.push_back(16'h0123); dir_v.push_back(16'h8555);
    pulse_start();
    wait_eoc();
    check("ferr_set", ferr[0], 1);
    check("ferr_adc_v", adc_v[0], 12'h555);
    dir_i.push_back(16'h0456); dir_v.push_back(16'h0789);
    pulse_start();
    wait_eoc();
    check("ferr_clear", ferr[0], 0);

    random_runs(6);

    // Reset 30 cycles into a frame aborts it.
    pulse_start();
    repeat (29) @(posedge clk);
    #1 reset[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_cs_n", cs_n[0], 1);
    check("abort_sclk", sclk[0], 1);
    check("abort_busy", busy[0], 0);
    check("abort_eoc", eoc[0], 0);
    check("abort_adc_i", adc_i[0], 0);
    check("abort_adc_v", adc_v[0], 0);
    check("abort_ferr", ferr[0], 0);

    // Fast configuration without auto-start.
    cur = 1;
    repeat (2) @(posedge clk);
    #1 reset[1] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("no_auto_cs_n", cs_n[1], 1);
    check("no_auto_busy", busy[1], 0);
    check("no_auto_eoc", eoc[1], 0);
    dir_i.push_back(16'h0ABC); dir_v.push_back(16'h0FED);
    pulse_start();
    wait_eoc();
    check("fast_adc_i", adc_i[1], 12'hABC);
    check("fast_adc_v", adc_v[1], 12'hFED);
    random_runs(6);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_dual_serial_capture.md
Name: adc_dual_serial_capture

Overview:
- Upstream stage of the conditioning FSM. Drives two simultaneous-sampling serial ADCs, one for the current (I) channel and one for the voltage (V) channel, over a shared CS_N/SCLK pair.
- Deserialises both data lines, presents the 12-bit I and V words, and raises EOC.
- The conditioning FSM latches the words on EOC and requests the next conversion with a START_ADC pulse.

Parameters:
- DATA_W, 12: ADC result width, taken from the LSBs of the frame.
- FRAME_BITS, 16: SCLK cycles per frame. Must be >= DATA_W.
- CLK_DIV, 2: CLK cycles per SCLK half-period. Must be >= 1.
- QUIET_CYC, 4: CLK cycles CS_N is held high after a frame before EOC.
- AUTO_START, 1: 1 = start one conversion automatically after reset release.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  active-low, synchronous; 0 = reset.
- START_ADC  in  1  single-cycle conversion request from the conditioning FSM.
- SDATA_I  in  1  serial data from the I-channel ADC, MSB first.
- SDATA_V  in  1  serial data from the V-channel ADC, MSB first.
- CS_N  out  1  shared ADC chip select, active low.
- SCLK  out  1  shared ADC serial clock; idles high.
- ADC_I  out  DATA_W  last captured I word, unsigned.
- ADC_V  out  DATA_W  last captured V word, unsigned.
- EOC  out  1  level: data valid; held until the next accepted START_ADC.
- BUSY  out  1  high from conversion start until EOC is set.
- FRAME_ERR  out  1  leading-zero violation in the last frame; updates with EOC.

Behaviour:
- Reset: the clock and reset are single-clock, synchronous, active-low as fixed above.
  - While RESET=0: CS_N=1, SCLK=1, EOC=0, BUSY=0, ADC_I=0, ADC_V=0, FRAME_ERR=0, state=IDLE, all counters 0.
  - Reset mid-frame aborts at that edge. No EOC is produced and the output words are unchanged from their reset value.
- States (registered): IDLE, SHIFT, QUIET.
- IDLE:
  - START_ADC=1 at edge N, or the first edge with RESET=1 when AUTO_START=1, is the start event.
  - At edge N: CS_N<=0, SCLK<=1, EOC<=0, BUSY<=1, bit and divider counters cleared, state<=SHIFT.
- SHIFT:
  - The divider counts 0..CLK_DIV-1. At the terminal count SCLK toggles.
  - SCLK falls first at N+CLK_DIV.
  - On each edge that drives SCLK 0->1, SDATA_I and SDATA_V are shifted into their FRAME_BITS-wide registers (MSB first) and the bit counter increments.
  - The FRAME_BITS-th rise occurs at N+2*CLK_DIV*FRAME_BITS. At that edge: CS_N<=1, SCLK stays 1, state<=QUIET.
- QUIET:
  - After QUIET_CYC cycles, at edge N+2*CLK_DIV*FRAME_BITS+QUIET_CYC (N+68 with defaults):
    - ADC_I<=shI[DATA_W-1:0] and ADC_V<=shV[DATA_W-1:0], updated in the same edge.
    - FRAME_ERR<=OR of the upper FRAME_BITS-DATA_W bits of both shift registers.
    - EOC<=1, BUSY<=0, state<=IDLE.
- START_ADC outside IDLE is ignored: no queueing, no error.
- START_ADC cannot coincide with EOC rising because QUIET ignores it.
- EOC stays 1 through IDLE. It drops on the edge that accepts the next START_ADC, so EOC is 0 in the cycle after START_ADC.
- ADC_I and ADC_V hold between EOCs and are never partially updated.
- SDATA is sampled without a synchronizer. The ADC timing budget is met through CLK_DIV.
- Widths: counters are sized with clog2(FRAME_BITS+1), clog2(CLK_DIV) and clog2(QUIET_CYC+1); no arithmetic overflow is possible.

Decomposition:
- Shared package acond_pkg:
  - State encoding localparams (IDLE/SHIFT/QUIET).
  - Default DATA_W and FRAME_BITS, shared with the conditioning FSM datapath registers.
- One sub-module, adc_sclk_gen: divider plus SCLK toggle. It outputs an sclk_rise strobe and is enabled only in SHIFT.
- The top level holds the FSM, shift registers, output registers and flags.

Test Plan:
- Reset release with AUTO_START=1, SDATA_I frame 0x0ABC, SDATA_V frame 0x0123 -> CS_N low at first edge; EOC=1 exactly 68 cycles later; ADC_I=0xABC, ADC_V=0x123, FRAME_ERR=0; exactly 16 SCLK rising edges while CS_N=0.
- EOC=1, START_ADC pulse, frames 0x0FFF/0x0000 -> EOC=0 on the next cycle, BUSY=1; after 68 cycles ADC_I=0xFFF, ADC_V=0x000; previous words held until then.
- START_ADC pulsed at cycles +5 and +40 of an active conversion -> ignored; single frame; EOC timing unchanged.
- Frame with leading bits 0x8xxx on SDATA_V only -> FRAME_ERR=1 at EOC; ADC_V holds the 12 LSBs; the next clean frame clears FRAME_ERR.
- RESET=0 asserted at cycle +30 of a frame -> next edge CS_N=1, SCLK=1, BUSY=0, EOC=0, words 0; with AUTO_START=0, no conversion until START_ADC.
- CLK_DIV=1, QUIET_CYC=1 -> EOC at N+33; SCLK period 2 CLK; data correct.
